// File: rtl/div3_pkg.sv
// rtl/div3_pkg.sv - shared types and radix constant for the serial divide-by-3 unit
// Optional feature macro: DIV3_FAST_EN (radix-4, two dividend bits per step)
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div3_state_t;

  typedef logic [1:0] div3_rem_t;

`ifdef DIV3_FAST_EN
  localparam int DIV3_RADIX_BITS = 2;
`else
  localparam int DIV3_RADIX_BITS = 1;
`endif

endpackage

// File: rtl/div3_step.sv
// rtl/div3_step.sv - one MSB-first remainder step of division by 3
// Optional feature macro: DIV3_FAST_EN (consumes two dividend bits per step)
// Ports:
//   rem      in   current partial remainder (0..2)
//   bits     in   next dividend bit(s), MSB first
//   q_bits   out  quotient bit(s) produced by this step
//   rem_next out  partial remainder after this step (0..2)
module div3_step
  import div3_pkg::*;
(
  input  div3_rem_t                  rem,
  input  logic [DIV3_RADIX_BITS-1:0] bits,
  output logic [DIV3_RADIX_BITS-1:0] q_bits,
  output div3_rem_t                  rem_next
);

  div3_rem_t rem_safe;

  // Code 3 cannot occur; fold it to 0 so a corrupted remainder recovers.
  assign rem_safe = (rem == 2'd3) ? 2'd0 : rem;

`ifdef DIV3_FAST_EN
  logic [3:0] v;
  logic [1:0] q;

  always_comb begin
    v = {rem_safe, bits};            // 4*rem + 2*b1 + b0, 0..11
    if (v >= 4'd9)      q = 2'd3;
    else if (v >= 4'd6) q = 2'd2;
    else if (v >= 4'd3) q = 2'd1;
    else                q = 2'd0;
    q_bits   = q;
    rem_next = 2'(v - 4'(q) * 4'd3);
  end
`else
  logic [2:0] v;

  always_comb begin
    v        = {rem_safe, bits};     // 2*rem + bit, 0..5
    q_bits   = (v >= 3'd3);
    rem_next = 2'(v - ((v >= 3'd3) ? 3'd3 : 3'd0));
  end
`endif

endmodule

// File: rtl/div3_serial.sv
// rtl/div3_serial.sv - bit-serial divide-by-3 on a valid/ready stream
// Optional feature macro: DIV3_FAST_EN (two bits per cycle, WIDTH must be even)
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid / in_ready / in_number  operand stream
//   out_valid / out_ready            result stream handshake
//   out_quotient                     floor(in_number / 3)
//   out_remainder                    in_number mod 3
//   out_divisible                    1 when the remainder is 0
module div3_serial
  import div3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [1:0]       out_remainder,
  output logic             out_divisible
);

  localparam int STEPS = WIDTH / DIV3_RADIX_BITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (WIDTH < 2) begin : g_width_small
    $error("div3_serial: WIDTH must be at least 2");
  end

`ifdef DIV3_FAST_EN
  if (WIDTH % 2 != 0) begin : g_width_odd
    $error("div3_serial: WIDTH must be even when DIV3_FAST_EN is defined");
  end
`endif

  div3_state_t state, state_next;

  // The dividend shifts out at the top while quotient bits shift in at the
  // bottom, so after the last step this register holds the whole quotient.
  logic [WIDTH-1:0]           shreg;
  logic [WIDTH-1:0]           shreg_next;
  div3_rem_t                  rem;
  div3_rem_t                  step_rem;
  logic [DIV3_RADIX_BITS-1:0] step_q;
  logic [CNT_W-1:0]           cnt;
  logic                       last_step;

  assign last_step  = (cnt == LAST_STEP);
  assign shreg_next = (shreg << DIV3_RADIX_BITS) | WIDTH'(step_q);

  div3_step u_step (
    .rem      (rem),
    .bits     (shreg[WIDTH-1 -: DIV3_RADIX_BITS]),
    .q_bits   (step_q),
    .rem_next (step_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg         <= '0;
      rem           <= '0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_divisible <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_number;
            rem   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          shreg <= shreg_next;
          rem   <= step_rem;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            out_quotient  <= shreg_next;
            out_remainder <= step_rem;
            out_divisible <= (step_rem == 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div3_serial.sv
// tb/tb_div3_serial.sv - directed and random bench for div3_serial
module tb_div3_serial;

  localparam int W = 16;
`ifdef DIV3_FAST_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_number;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [1:0]   out_remainder;
  logic         out_divisible;

  int n_checks = 0;
  int n_fail   = 0;

  div3_serial #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_number     (in_number),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_divisible (out_divisible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept(input logic [W-1:0] n);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid  = 1'b1;
    in_number = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] q,
                              input logic [1:0] r);
    check({tag, "_quot"}, out_quotient, q);
    check({tag, "_rem"},  out_remainder, r);
    check({tag, "_div"},  out_divisible, (r == 2'd0));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_hs_ready"}, in_ready, 1);
    check({tag, "_hs_valid"}, out_valid, 0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] n,
                       input logic [W-1:0] q, input logic [1:0] r);
    int lat;
    accept(n);
    wait_valid(lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_busy"}, in_ready, 0);
    check_result(tag, q, r);
    handshake(tag);
  endtask

  initial begin
    int lat;
    logic [W-1:0] n;
    logic seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_number = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quot", out_quotient, 0);
    check("rst_rem", out_remainder, 0);
    check("rst_div", out_divisible, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("zero",  16'd0,     16'd0,     2'd0);
    do_op("ffff",  16'hFFFF,  16'h5555,  2'd0);
    do_op("fffe",  16'd65534, 16'd21844, 2'd2);
    do_op("one",   16'd1,     16'd0,     2'd1);
    do_op("two",   16'd2,     16'd0,     2'd2);
    do_op("fffd",  16'd65533, 16'd21844, 2'd1);

    // Back-to-back with out_ready tied high and in_valid held high.
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    in_number = 16'd100;
    @(posedge clk);
    #1;
    in_number = 16'd3;
    wait_valid(lat);
    check("b2b_lat0", lat, LAT);
    check_result("b2b_100", 16'd33, 2'd1);
    check("b2b_no_ready_in_done", in_ready, 0);
    @(posedge clk);
    #1;
    check("b2b_ready_after_hs", in_ready, 1);
    check("b2b_valid_after_hs", out_valid, 0);
    @(posedge clk);
    #1;
    check("b2b_second_taken", in_ready, 0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_lat1", lat, LAT);
    check_result("b2b_3", 16'd1, 2'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b_final_ready", in_ready, 1);

    // Back-pressure: DONE holds while in_valid pulses are ignored.
    accept(16'd65534);
    wait_valid(lat);
    check("bp_lat", lat, LAT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid  = (i % 2 == 0);
      in_number = 16'd9;
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_quot", out_quotient, 16'd21844);
      check("bp_rem", out_remainder, 2'd2);
    end
    in_valid = 1'b0;
    handshake("bp");
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("bp_single_hs", seen, 0);
    check("bp_idle_hold_quot", out_quotient, 16'd21844);
    check("bp_idle_ready", in_ready, 1);

    // Reset at RUN step 5 discards the operation.
    accept(16'hFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_quot", out_quotient, 0);
    check("mid_rst_rem", out_remainder, 0);
    check("mid_rst_div", out_divisible, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 0);
    do_op("seven", 16'd7, 16'd2, 2'd1);

    // Random sweep against n/3, n%3.
    for (int i = 0; i < 300; i++) begin
      n = W'($urandom);
      do_op("rand", n, n / 3, 2'(n % 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
